// File: rtl/fht_mtx_tm_nxn.sv
// Ping-pong N x N matrix transposer.
// Words arrive row-major into one bank while the other bank is read out in
// column-major (transposed) order. Two full flags arbitrate the banks.
// Optional feature (macro MTX_TM_BYPASS_EN): adds a per-block bypass input
// that, when sampled high with word 0, reads that block back in input order.
module fht_mtx_tm_nxn #(
  parameter int DW    = 16,
  parameter int LOG2N = 3
) (
  input  logic          sclk,
  input  logic          rstn,
`ifdef MTX_TM_BYPASS_EN
  input  logic          bypass,
`endif
  input  logic          inp_valid,
  input  logic [DW-1:0] inp_data,
  output logic          inp_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam int AW = 2 * LOG2N;
  localparam int NN = 1 << AW;

  logic [DW-1:0] mem [2][NN];
  logic [1:0]    full;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          rd_en;
  logic          rd_tp;
  logic          wr_end;
  logic          rd_end;

  assign inp_ready = ~full[wr_ptr];
  assign wr_en     = inp_valid & inp_ready;
  // A read only starts on a full bank and a write only on an empty one, so
  // the two sides always touch different banks.
  assign rd_en     = full[rd_ptr] & (~out_valid | out_ready);
  assign wr_end    = &wr_cnt;
  assign rd_end    = &rd_cnt;

`ifdef MTX_TM_BYPASS_EN
  logic [1:0] byp;

  assign rd_tp = ~byp[rd_ptr];

  // Capture the bypass mode of each block with its first word.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      byp <= 2'b00;
    end else if (wr_en && (wr_cnt == '0)) begin
      byp[wr_ptr] <= bypass;
    end
  end
`else
  assign rd_tp = 1'b1;
`endif

  // Swapping the row and column halves of the counter walks the bank by column.
  assign rd_addr = rd_tp ? {rd_cnt[LOG2N-1:0], rd_cnt[AW-1:LOG2N]} : rd_cnt;

  // Bank storage; contents are don't-care until the full flag says otherwise.
  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem[wr_ptr][wr_cnt] <= inp_data;
    end
  end

  // Write side: count words, mark the bank full and flip on the last word.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt <= '0;
      wr_ptr <= 1'b0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + AW'(1);
      if (wr_end) begin
        wr_ptr <= ~wr_ptr;
      end
    end
  end

  // Full flags: set by the write side, cleared by the read side.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      full <= 2'b00;
    end else begin
      if (wr_en && wr_end) begin
        full[wr_ptr] <= 1'b1;
      end
      if (rd_en && rd_end) begin
        full[rd_ptr] <= 1'b0;
      end
    end
  end

  // Read side: registered output stage that holds under backpressure.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt    <= '0;
      rd_ptr    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (rd_en) begin
      out_data  <= mem[rd_ptr][rd_addr];
      out_valid <= 1'b1;
      out_last  <= rd_end;
      rd_cnt    <= rd_cnt + AW'(1);
      if (rd_end) begin
        rd_ptr <= ~rd_ptr;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
